// File: rtl/indicator_driver_pkg.sv
// Shared definitions for the indicator LED driver: mode encodings, FSM state
// encoding, and clock-derived timing defaults.
package indicator_driver_pkg;

    // System clock and human-visible timing defaults
    localparam int unsigned CLK_HZ            = 12_000_000;
    localparam int unsigned PULSE_MS          = 100;
    localparam int unsigned BLINK_MS          = 250;
    localparam int unsigned PULSE_CYCLES_DFLT = (CLK_HZ / 1000) * PULSE_MS;
    localparam int unsigned BLINK_HALF_DFLT   = (CLK_HZ / 1000) * BLINK_MS;
    localparam int unsigned CNT_W_DFLT        = 22;

    // Steady-state mode request driven by the parking-lot controller
    localparam int unsigned MODE_W = 2;
    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_OFF   = 2'b00;
    localparam mode_t MODE_ON    = 2'b01;
    localparam mode_t MODE_BLINK = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ON       = 3'd1,
        ST_BLINK_HI = 3'd2,
        ST_BLINK_LO = 3'd3,
        ST_PULSE    = 3'd4
    } state_e;

    // Entry state for a mode; reserved encoding behaves as OFF
    function automatic state_e mode_target(input mode_t m);
        state_e s;
        case (m)
            MODE_ON:    s = ST_ON;
            MODE_BLINK: s = ST_BLINK_HI;
            default:    s = ST_IDLE;
        endcase
        return s;
    endfunction

    // True when a steady state already serves the requested target
    function automatic logic state_matches(input state_e s, input state_e tgt);
        logic m;
        if (tgt == ST_BLINK_HI) m = (s == ST_BLINK_HI) || (s == ST_BLINK_LO);
        else                    m = (s == tgt);
        return m;
    endfunction

endpackage

// File: rtl/indicator_driver_if.sv
// Controller <-> indicator driver connection.
//   mode : steady-state request (OFF/ON/BLINK), controller -> driver
//   trig : one-shot pulse request, controller -> driver
//   led  : registered LED drive, driver -> pad/controller
//   busy : stretched pulse in progress, driver -> controller
interface indicator_driver_if;
    indicator_driver_pkg::mode_t mode;
    logic                        trig;
    logic                        led;
    logic                        busy;

    modport master (output mode, output trig, input  led,  input  busy);
    modport slave  (input  mode, input  trig, output led,  output busy);
endinterface

// File: rtl/indicator_driver.sv
// Converts single-clock controller events and mode levels into LED drive:
// steady on/off, 50% blink, or a retriggerable stretched pulse.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   ind   : slave side of indicator_driver_if (mode, trig in; led, busy out)
module indicator_driver
    import indicator_driver_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DFLT,
    parameter int unsigned BLINK_HALF   = BLINK_HALF_DFLT,
    parameter int unsigned CNT_W        = CNT_W_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    indicator_driver_if.slave  ind
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             led_q,   led_d;
    logic             busy_q,  busy_d;
    state_e           tgt;

    // State, shared counter and registered output decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    // Next state / counter; outputs decode the next state so they line up
    // with the state register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt     = mode_target(ind.mode);

        if (ind.trig) begin
            // Any trigger (re)starts a full pulse window
            state_d = ST_PULSE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    // Mode is only consulted when the pulse expires
                    if (cnt_q == PULSE_LAST) begin
                        state_d = tgt;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    if (!state_matches(state_q, tgt)) begin
                        state_d = tgt;
                        cnt_d   = '0;
                    end else if (state_q == ST_BLINK_HI || state_q == ST_BLINK_LO) begin
                        if (cnt_q == BLINK_LAST) begin
                            state_d = (state_q == ST_BLINK_HI) ? ST_BLINK_LO : ST_BLINK_HI;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            endcase
        end

        led_d  = (state_d == ST_ON) || (state_d == ST_BLINK_HI) || (state_d == ST_PULSE);
        busy_d = (state_d == ST_PULSE);
    end

    assign ind.led  = led_q;
    assign ind.busy = busy_q;

endmodule

// File: tb/tb_indicator_driver.sv
// Self-checking bench for indicator_driver with short timing parameters.
// A behavioural model (pulse age / blink phase) predicts {led,busy} per edge;
// predictions are queued when stimulus is driven and checked after the edge.
module tb_indicator_driver;
    import indicator_driver_pkg::*;

    localparam int unsigned P  = 5;
    localparam int unsigned B  = 3;
    localparam int unsigned CW = 3;

    logic clk;
    logic rst_n;
    indicator_driver_if ind ();

    indicator_driver #(
        .PULSE_CYCLES (P),
        .BLINK_HALF   (B),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ind   (ind.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got led/busy=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: class 0=off 1=on 2=blink 3=pulse
    int  m_cls;
    int  m_age;
    int  m_pos;
    logic [1:0] sb_q[$];

    function automatic int mode_class(input logic [1:0] m);
        if (m == 2'b01) return 1;
        if (m == 2'b10) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] steady_out(input int cls, input int pos);
        if (cls == 1) return 2'b10;
        if (cls == 2) return ((pos % (2 * B)) < B) ? 2'b10 : 2'b00;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_cls = 0;
        m_age = 0;
        m_pos = 0;
    endtask

    function automatic logic [1:0] model_edge(input logic t, input logic [1:0] m);
        int nc;
        if (t) begin
            m_cls = 3;
            m_age = 0;
            return 2'b11;
        end
        if (m_cls == 3) begin
            m_age++;
            if (m_age < P) return 2'b11;
            m_cls = mode_class(m);
            m_pos = 0;
            return steady_out(m_cls, m_pos);
        end
        nc = mode_class(m);
        if (nc == 2 && m_cls == 2) m_pos++;
        else                       m_pos = 0;
        m_cls = nc;
        return steady_out(m_cls, m_pos);
    endfunction

    // Drive one cycle of stimulus, predict, then compare after the edge
    task automatic step(input string tag, input logic t, input logic [1:0] m);
        logic [1:0] exp;
        ind.trig = t;
        ind.mode = m;
        sb_q.push_back(model_edge(t, m));
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check(tag, {ind.led, ind.busy}, exp);
    endtask

    // Asynchronous reset in the middle of a cycle, released before the next edge
    task automatic mid_reset(input string tag, input logic [1:0] m);
        #2 rst_n = 1'b0;
        #1 check(tag, {ind.led, ind.busy}, 2'b00);
        model_reset();
        ind.trig = 1'b0;
        ind.mode = m;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ind.trig = 1'b0;
        ind.mode = MODE_OFF;
        model_reset();
        #3 check("reset_state", {ind.led, ind.busy}, 2'b00);
        ind.mode = MODE_ON;
        #4 rst_n = 1'b1;

        // Steady modes
        for (int i = 0; i < 3; i++) step("steady_on", 1'b0, MODE_ON);
        for (int i = 0; i < 2; i++) step("steady_off", 1'b0, MODE_OFF);

        // Blink from IDLE: 1,1,1,0,0,0 repeating
        for (int i = 0; i < 12; i++) step("blink", 1'b0, MODE_BLINK);
        for (int i = 0; i < 2; i++) step("blink_to_on", 1'b0, MODE_ON);
        for (int i = 0; i < 4; i++) step("blink_restart", 1'b0, MODE_BLINK);

        // Single pulse over OFF
        step("pulse_off_pre", 1'b0, MODE_OFF);
        step("pulse_trig", 1'b1, MODE_OFF);
        for (int i = 0; i < 7; i++) step("pulse_single", 1'b0, MODE_OFF);

        // Retrigger at pulse cycle 3 extends without a gap
        step("retrig_t0", 1'b1, MODE_OFF);
        for (int i = 0; i < 2; i++) step("retrig_mid", 1'b0, MODE_OFF);
        step("retrig_t3", 1'b1, MODE_OFF);
        for (int i = 0; i < 7; i++) step("retrig_tail", 1'b0, MODE_OFF);

        // Pulse over BLINK_LO with mode change mid-pulse
        for (int i = 0; i < 4; i++) step("blink_lo_setup", 1'b0, MODE_BLINK);
        step("pob_trig", 1'b1, MODE_BLINK);
        step("pob_c1", 1'b0, MODE_BLINK);
        for (int i = 0; i < 7; i++) step("pob_mode_on", 1'b0, MODE_ON);

        // Trigger coincident with a mode change
        step("coinc_trig", 1'b1, MODE_BLINK);
        for (int i = 0; i < 8; i++) step("coinc_tail", 1'b0, MODE_BLINK);

        // Reset mid-pulse
        step("rst_pulse_trig", 1'b1, MODE_OFF);
        step("rst_pulse_c1", 1'b0, MODE_OFF);
        mid_reset("reset_mid_pulse", MODE_OFF);
        for (int i = 0; i < 3; i++) step("post_reset_off", 1'b0, MODE_OFF);

        // Reset mid-blink
        for (int i = 0; i < 2; i++) step("blink_pre_rst", 1'b0, MODE_BLINK);
        mid_reset("reset_mid_blink", MODE_OFF);
        step("post_reset_blink", 1'b0, MODE_OFF);

        // Reserved mode behaves as OFF
        for (int i = 0; i < 2; i++) step("reserved_mode", 1'b0, 2'b11);

        // Random mix including reserved mode and held trig
        for (int i = 0; i < 200; i++)
            step("random", ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)));

        check("sb_drained", 2'(sb_q.size()), 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
